// File: rtl/axi_burst_writer.sv
// AXI write master: drains a valid/ready word stream into INCR bursts over a linear address range.
// Optional build macro ABORT_ON_SLVERR_EN: a non-OKAY write response ends the job early.
module axi_burst_writer #(
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 16
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] total_words,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic [31:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             AWID,
    output logic [31:0]      AWADDR,
    output logic [7:0]       AWLEN,
    output logic [2:0]       AWSIZE,
    output logic [1:0]       AWBURST,
    output logic             AWVALID,
    input  logic             AWREADY,
    output logic             WID,
    output logic [31:0]      WDATA,
    output logic [3:0]       WSTRB,
    output logic             WLAST,
    output logic             WVALID,
    input  logic             WREADY,
    output logic             BREADY,
    input  logic             BID,
    input  logic [1:0]       BRESP,
    input  logic             BVALID
);

    // state | meaning
    // IDLE  | waiting for start
    // AW    | burst address offered
    // W     | streaming beats straight from the source
    // B     | waiting for the write response
    // FIN   | one-cycle done pulse
    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_FIN} state_t;

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [31:0]      awaddr_q, awaddr_d;
    logic [7:0]       awlen_q, awlen_d;
    logic             err_q, err_d;
    logic             resp_taken;
    logic [8:0]       burst_beats;
    logic             unused_bid;

    assign unused_bid = BID;

    // Beats limited by words left, MAX_BURST and the room left in the current 4 KB page.
    function automatic logic [7:0] calc_awlen(input logic [31:0] a, input logic [CNT_W-1:0] r);
        logic [31:0] n;
        logic [31:0] room;
        n = 32'(r);
        if (n > 32'(MAX_BURST)) n = 32'(MAX_BURST);
        room = 32'd1024 - {22'd0, a[11:2]};
        if (n > room) n = room;
        return 8'(n - 32'd1);
    endfunction

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            awaddr_q <= '0;
            awlen_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            awaddr_q <= awaddr_d;
            awlen_q  <= awlen_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        err_d       = err_q;
        resp_taken  = 1'b0;
        burst_beats = {1'b0, awlen_q} + 9'd1;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (total_words != '0) begin
                        addr_d  = {base_addr[31:2], 2'b00};
                        rem_d   = total_words;
                        state_d = S_AW;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_AW: begin
                if (AWREADY) begin
                    cnt_d   = '0;
                    state_d = S_W;
                end
            end
            S_W: begin
                if (s_valid && WREADY) begin
                    cnt_d = cnt_q + 8'd1;
                    rem_d = rem_q - CNT_W'(1);
                    if (cnt_q == awlen_q) begin
                        // A slave answering combinationally with WLAST lets us skip B.
                        if (BVALID) resp_taken = 1'b1;
                        else        state_d    = S_B;
                    end
                end
            end
            S_B: begin
                if (BVALID) resp_taken = 1'b1;
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (resp_taken) begin
            addr_d = addr_q + {21'd0, burst_beats, 2'b00};
            if (BRESP != 2'b00) err_d = 1'b1;
`ifdef ABORT_ON_SLVERR_EN
            state_d = (BRESP != 2'b00 || rem_d == '0) ? S_FIN : S_AW;
`else
            state_d = (rem_d == '0) ? S_FIN : S_AW;
`endif
        end

        if (state_d == S_AW && state_q != S_AW) begin
            awaddr_d = addr_d;
            awlen_d  = calc_awlen(addr_d, rem_d);
        end
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        WLAST   = 1'b0;
        s_ready = 1'b0;
        BREADY  = 1'b0;
        case (state_q)
            S_AW: begin
                busy    = 1'b1;
                AWVALID = 1'b1;
            end
            S_W: begin
                busy    = 1'b1;
                WVALID  = s_valid;
                s_ready = WREADY;
                WLAST   = (cnt_q == awlen_q);
                BREADY  = 1'b1;
            end
            S_B: begin
                busy   = 1'b1;
                BREADY = 1'b1;
            end
            S_FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign err     = err_q;
    assign AWADDR  = awaddr_q;
    assign AWLEN   = awlen_q;
    assign AWID    = 1'b0;
    assign WID     = 1'b0;
    assign AWSIZE  = 3'b010;
    assign AWBURST = 2'b01;
    assign WSTRB   = 4'hF;
    assign WDATA   = s_data;

endmodule

// File: tb/tb_axi_burst_writer.sv
// Scoreboard bench for axi_burst_writer: directed jobs, expected bursts/beats queued up front,
// a negedge monitor pops and compares on every handshake.
module tb_axi_burst_writer;
    localparam int CNT_W = 16;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    logic             start = 1'b0;
    logic [31:0]      base_addr = '0;
    logic [CNT_W-1:0] total_words = '0;
    logic             busy, done, err;
    logic [31:0]      s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic             AWID, AWVALID, WID, WLAST, WVALID, BREADY;
    logic [31:0]      AWADDR, WDATA;
    logic [7:0]       AWLEN;
    logic [2:0]       AWSIZE;
    logic [1:0]       AWBURST;
    logic [3:0]       WSTRB;
    logic             AWREADY = 1'b1;
    logic             WREADY = 1'b1;
    logic             BID = 1'b0;
    logic [1:0]       BRESP;
    logic             BVALID;

    axi_burst_writer #(.MAX_BURST(16), .CNT_W(CNT_W)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .start(start), .base_addr(base_addr),
        .total_words(total_words), .busy(busy), .done(done), .err(err),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB),
        .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY), .BREADY(BREADY), .BID(BID),
        .BRESP(BRESP), .BVALID(BVALID)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [39:0] exp_aw[$];
    logic [32:0] exp_w[$];
    logic [31:0] src_q[$];
    logic [1:0]  resp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave model: BVALID one cycle after WLAST, or combinational with WLAST in comb_b mode.
    logic       bvalid_r = 1'b0;
    logic [1:0] bresp_r = 2'b00;
    bit         comb_b = 1'b0;
    assign BVALID = comb_b ? (WVALID & WREADY & WLAST) : bvalid_r;
    assign BRESP  = bresp_r;

    initial begin
        logic awhs, lhs, bhs;
        forever begin
            @(negedge ACLK);
            awhs = AWVALID & AWREADY;
            lhs  = WVALID & WREADY & WLAST;
            bhs  = BVALID & BREADY;
            @(posedge ACLK); #1;
            if (!ARESETn) begin
                bvalid_r = 1'b0;
            end else begin
                if (awhs) bresp_r = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
                if (bhs) bvalid_r = 1'b0;
                if (lhs && !comb_b) bvalid_r = 1'b1;
            end
        end
    end

    // Source model: presents src_q head; optional 1/0 toggling of s_valid.
    bit   tog_mode = 1'b0;
    logic tog = 1'b1;
    initial begin
        logic shs;
        forever begin
            @(negedge ACLK);
            shs = s_valid & s_ready;
            @(posedge ACLK); #1;
            if (shs && src_q.size() > 0) void'(src_q.pop_front());
            tog     = ~tog;
            s_valid = (src_q.size() > 0) && (!tog_mode || tog);
            s_data  = (src_q.size() > 0) ? src_q[0] : 32'h0;
        end
    end

    int cyc = 0, done_cnt = 0, beat_cnt = 0, last_cyc = 0, done_cyc = 0, start_cyc = 0;
    bit chk_wv = 1'b0;

    initial begin
        logic [39:0] ea;
        logic [32:0] ew;
        forever begin
            @(negedge ACLK);
            cyc++;
            if (ARESETn) begin
                if (AWVALID && AWREADY) begin
                    if (exp_aw.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL aw_unexpected: got AWADDR %0h AWLEN %0d, expected no burst", AWADDR, AWLEN);
                    end else begin
                        ea = exp_aw.pop_front();
                        check("awaddr", AWADDR, ea[31:0]);
                        check("awlen", AWLEN, ea[39:32]);
                    end
                end
                if (WVALID && WREADY) begin
                    beat_cnt++;
                    if (WLAST) last_cyc = cyc;
                    if (exp_w.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL w_unexpected: got WDATA %0h, expected no beat", WDATA);
                    end else begin
                        ew = exp_w.pop_front();
                        check("wdata", WDATA, ew[31:0]);
                        check("wlast", WLAST, ew[32]);
                    end
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (chk_wv && BREADY) check("wvalid_follows_s_valid", WVALID, s_valid);
                if (!BREADY) check("s_ready_outside_w", s_ready, 1'b0);
            end
        end
    end

    task automatic expect_burst(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] first);
        exp_aw.push_back({len, addr});
        for (int j = 0; j <= int'(len); j++)
            exp_w.push_back({(j == int'(len)), first + 32'(j)});
    endtask

    task automatic feed(input int n, input logic [31:0] first);
        for (int i = 0; i < n; i++) src_q.push_back(first + 32'(i));
    endtask

    task automatic start_job(input logic [31:0] base, input int n);
        @(posedge ACLK); #2;
        start = 1'b1;
        base_addr = base;
        total_words = n[CNT_W-1:0];
        @(negedge ACLK); #1;
        start_cyc = cyc;
        @(posedge ACLK); #2;
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 400 && done_cnt == d0; i++) @(posedge ACLK);
        repeat (2) @(posedge ACLK);
        #2;
        check("done_pulses", done_cnt - d0, 1);
        check("busy_after_done", busy, 1'b0);
        check("aw_left", exp_aw.size(), 0);
        check("w_left", exp_w.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awvalid"}, AWVALID, 1'b0);
        check({tag, "_wvalid"}, WVALID, 1'b0);
        check({tag, "_bready"}, BREADY, 1'b0);
        check({tag, "_wlast"}, WLAST, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_awaddr"}, AWADDR, 32'h0);
        check({tag, "_awlen"}, AWLEN, 8'h0);
        check({tag, "_s_ready"}, s_ready, 1'b0);
    endtask

    initial begin
        int d0, b0;
        #1;
        check_reset_outputs("reset");
        check("awid", AWID, 1'b0);
        check("wid", WID, 1'b0);
        check("awsize", AWSIZE, 3'b010);
        check("awburst", AWBURST, 2'b01);
        check("wstrb", WSTRB, 4'hF);
        repeat (3) @(posedge ACLK);
        #2 ARESETn = 1'b1;

        // 40 words from 0x1000: 16+16+8, plus an ignored start mid-job
        feed(40, 32'hA000_0000);
        expect_burst(32'h1000, 8'd15, 32'hA000_0000);
        expect_burst(32'h1040, 8'd15, 32'hA000_0010);
        expect_burst(32'h1080, 8'd7,  32'hA000_0020);
        d0 = done_cnt;
        start_job(32'h1000, 40);
        repeat (3) @(posedge ACLK);
        #2 start = 1'b1; base_addr = 32'h9000; total_words = 16'd3;
        @(posedge ACLK); #2 start = 1'b0;
        wait_done(d0);
        check("err_job1", err, 1'b0);

        // 4 KB boundary split; low address bits ignored
        feed(6, 32'hB000_0000);
        expect_burst(32'h0FF8, 8'd1, 32'hB000_0000);
        expect_burst(32'h1000, 8'd3, 32'hB000_0002);
        d0 = done_cnt;
        start_job(32'h0FFB, 6);
        wait_done(d0);

        // combinational B with the single beat: FIN directly after the beat
        comb_b = 1'b1;
        feed(1, 32'hC000_0000);
        expect_burst(32'h2000, 8'd0, 32'hC000_0000);
        d0 = done_cnt;
        start_job(32'h2000, 1);
        wait_done(d0);
        check("comb_b_done_lag", done_cyc - last_cyc, 1);
        comb_b = 1'b0;

        // toggling s_valid
        tog_mode = 1'b1;
        chk_wv = 1'b1;
        b0 = beat_cnt;
        feed(8, 32'hD000_0000);
        expect_burst(32'h3000, 8'd7, 32'hD000_0000);
        d0 = done_cnt;
        start_job(32'h3000, 8);
        wait_done(d0);
        check("toggle_beats", beat_cnt - b0, 8);
        tog_mode = 1'b0;
        chk_wv = 1'b0;

        // zero-word job
        d0 = done_cnt;
        start_job(32'h7000, 0);
        wait_done(d0);
        check("zero_done_lag", done_cyc - start_cyc, 1);

        // SLVERR on the first of two bursts
        resp_q.push_back(2'b10);
        resp_q.push_back(2'b00);
        feed(20, 32'hE000_0000);
        expect_burst(32'h4000, 8'd15, 32'hE000_0000);
`ifndef ABORT_ON_SLVERR_EN
        expect_burst(32'h4040, 8'd3, 32'hE000_0010);
`endif
        d0 = done_cnt;
        start_job(32'h4000, 20);
        wait_done(d0);
        check("err_slverr", err, 1'b1);
`ifdef ABORT_ON_SLVERR_EN
        check("src_left_abort", src_q.size(), 4);
`else
        check("src_left_noabort", src_q.size(), 0);
`endif
        src_q.delete();
        resp_q.delete();
        repeat (2) @(posedge ACLK);

        // next accepted start clears err
        d0 = done_cnt;
        start_job(32'h0, 0);
        check("err_cleared", err, 1'b0);
        wait_done(d0);

        // reset mid-W
        feed(16, 32'hF000_0000);
        expect_burst(32'h5000, 8'd15, 32'hF000_0000);
        b0 = beat_cnt;
        start_job(32'h5000, 16);
        for (int i = 0; i < 100 && beat_cnt < b0 + 3; i++) @(posedge ACLK);
        @(posedge ACLK); #3;
        ARESETn = 1'b0;
        #1;
        check_reset_outputs("midw_reset");
        exp_aw.delete();
        exp_w.delete();
        src_q.delete();
        repeat (2) @(posedge ACLK);
        #2 ARESETn = 1'b1;
        repeat (4) @(posedge ACLK);
        #2;
        check("idle_after_reset", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
